// File: rtl/audio_pll_pkg.sv
// Shared types for the audio PLL reset sequencer.
//   state_t     : sequencer state encoding (3-bit)
//   ctrl_t      : the four per-state control outputs, kept together
//   state_ctrl  : control outputs that belong to a given state
package audio_pll_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned RETRY_CNT_W = 2;
  localparam int unsigned LOL_CNT_W   = 8;
  localparam int unsigned LOL_CNT_MAX = 255;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic audio_rst;
    logic pll_ready;
    logic fault;
  } ctrl_t;

  // Control outputs are a pure function of the state being entered.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c.pll_rst   = 1'b1;
    c.audio_rst = 1'b1;
    c.pll_ready = 1'b0;
    c.fault     = 1'b0;
    case (s)
      PLL_RST:   c.pll_rst = 1'b1;
      WAIT_LOCK: c.pll_rst = 1'b0;
      STABLE:    c.pll_rst = 1'b0;
      RUN: begin
        c.pll_rst   = 1'b0;
        c.audio_rst = 1'b0;
        c.pll_ready = 1'b1;
      end
      FAULT:     c.fault = 1'b1;
      default:   c.pll_rst = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/audio_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : async active-high reset, both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module audio_bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/audio_pll_reset_sequencer.sv
// Bring-up sequencer for the audio PLL (50 MHz refclk -> 12.288 MHz codec clock).
// Pulses the PLL reset, waits for lock with a timeout, qualifies lock stability,
// then releases the audio-domain reset. Retries on timeout, latches a fault after
// too many retries, and re-sequences on loss of lock.
//   refclk    : reference clock, sole clock
//   rst       : async active-high reset
//   restart   : 1-cycle pulse, re-sequence from PLL_RST (wins over everything)
//   locked    : PLL lock, asynchronous to refclk
//   pll_rst   : reset to the PLL
//   audio_rst : reset to the audio domain (active-high)
//   pll_ready : high only in RUN
//   fault     : high only in FAULT
//   retry_cnt : lock timeouts in the current bring-up
//   lol_cnt   : loss-of-lock events since rst, saturating
module audio_pll_reset_sequencer
  import audio_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 17
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic                   audio_rst,
  output logic                   pll_ready,
  output logic                   fault,
  output logic [RETRY_CNT_W-1:0] retry_cnt,
  output logic [LOL_CNT_W-1:0]   lol_cnt
);

  localparam logic [CNT_W-1:0]       RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]       TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]       STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT  = RETRY_CNT_W'(MAX_RETRIES);
  localparam logic [LOL_CNT_W-1:0]   LOL_SAT      = LOL_CNT_W'(LOL_CNT_MAX);

  state_t           state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             lock_s;

  // Bring locked into the refclk domain; every decision uses lock_s.
  audio_bit_sync #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  assign cnt_zero = (cnt == '0);

  // Sequencer: state, shared down-counter, counters and control outputs.
  // Each transition reloads the counter and registers the new state's outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= RST_LOAD;
      ctrl      <= state_ctrl(PLL_RST);
      retry_cnt <= '0;
      lol_cnt   <= '0;
    end else begin
      // Count down while staying put; a transition below overrides with a reload.
      if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (restart) begin
        // Restart wins in every state; in PLL_RST it stretches the pulse.
        state     <= PLL_RST;
        cnt       <= RST_LOAD;
        ctrl      <= state_ctrl(PLL_RST);
        retry_cnt <= '0;
      end else begin
        case (state)
          PLL_RST: begin
            if (cnt_zero) begin
              state <= WAIT_LOCK;
              cnt   <= TIMEOUT_LOAD;
              ctrl  <= state_ctrl(WAIT_LOCK);
            end
          end

          WAIT_LOCK: begin
            if (lock_s) begin
              state <= STABLE;
              cnt   <= STABLE_LOAD;
              ctrl  <= state_ctrl(STABLE);
            end else if (cnt_zero) begin
              if (retry_cnt == RETRY_LIMIT) begin
                state <= FAULT;
                cnt   <= '0;
                ctrl  <= state_ctrl(FAULT);
              end else begin
                state     <= PLL_RST;
                cnt       <= RST_LOAD;
                ctrl      <= state_ctrl(PLL_RST);
                retry_cnt <= retry_cnt + RETRY_CNT_W'(1);
              end
            end
          end

          STABLE: begin
            // A lock drop beats a coincident expiry; it is not a retry.
            if (!lock_s) begin
              state <= WAIT_LOCK;
              cnt   <= TIMEOUT_LOAD;
              ctrl  <= state_ctrl(WAIT_LOCK);
            end else if (cnt_zero) begin
              state     <= RUN;
              cnt       <= '0;
              ctrl      <= state_ctrl(RUN);
              retry_cnt <= '0;
            end
          end

          RUN: begin
            if (!lock_s) begin
              state <= PLL_RST;
              cnt   <= RST_LOAD;
              ctrl  <= state_ctrl(PLL_RST);
              if (lol_cnt != LOL_SAT) begin
                lol_cnt <= lol_cnt + LOL_CNT_W'(1);
              end
            end
          end

          FAULT: begin
            // Held until restart or rst.
            cnt <= '0;
          end

          default: begin
            state <= PLL_RST;
            cnt   <= RST_LOAD;
            ctrl  <= state_ctrl(PLL_RST);
          end
        endcase
      end
    end
  end

  assign pll_rst   = ctrl.pll_rst;
  assign audio_rst = ctrl.audio_rst;
  assign pll_ready = ctrl.pll_ready;
  assign fault     = ctrl.fault;

endmodule

// File: tb/tb_audio_pll_reset_sequencer.sv
// Self-checking bench for audio_pll_reset_sequencer with small timing parameters.
module tb_audio_pll_reset_sequencer;

  localparam int RST_CYC = 4;
  localparam int TMO     = 20;
  localparam int STB     = 8;
  localparam int MAXR    = 2;

  logic       refclk  = 1'b0;
  logic       rst     = 1'b1;
  logic       restart = 1'b0;
  logic       locked  = 1'b0;
  logic       pll_rst, audio_rst, pll_ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 refclk = ~refclk;

  audio_pll_reset_sequencer #(
    .RST_CYCLES    (RST_CYC),
    .LOCK_TIMEOUT  (TMO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MAXR),
    .CNT_W         (5)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .restart   (restart),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .audio_rst (audio_rst),
    .pll_ready (pll_ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (!pll_ready && n < budget) begin
      @(negedge refclk);
      n++;
    end
    chk(name, int'(pll_ready), 1);
  endtask

  // Behavioural model: phase plus cycles spent in it, lock seen two edges late.
  typedef enum int {M_RESET, M_WAIT, M_QUAL, M_RUN, M_FAULT} phase_t;
  phase_t m_ph      = M_RESET;
  int     m_el      = 0;
  int     m_retries = 0;
  int     m_lol     = 0;
  bit     lh0       = 1'b0;
  bit     lh1       = 1'b0;

  task automatic enter(input phase_t p);
    m_ph = p;
    m_el = 0;
  endtask

  initial begin
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) begin
        enter(M_RESET);
        m_retries = 0;
        m_lol     = 0;
        lh0       = 1'b0;
        lh1       = 1'b0;
      end else begin
        bit ls;
        ls  = lh1;
        lh1 = lh0;
        lh0 = locked;
        if (restart) begin
          enter(M_RESET);
          m_retries = 0;
        end else begin
          case (m_ph)
            M_RESET: if (m_el == RST_CYC - 1) enter(M_WAIT); else m_el++;
            M_WAIT: begin
              if (ls) enter(M_QUAL);
              else if (m_el == TMO - 1) begin
                if (m_retries == MAXR) enter(M_FAULT);
                else begin
                  m_retries++;
                  enter(M_RESET);
                end
              end else m_el++;
            end
            M_QUAL: begin
              if (!ls) enter(M_WAIT);
              else if (m_el == STB - 1) begin
                enter(M_RUN);
                m_retries = 0;
              end else m_el++;
            end
            M_RUN: begin
              if (!ls) begin
                enter(M_RESET);
                if (m_lol < 255) m_lol++;
              end
            end
            default: m_el = 0;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge refclk);
      if (cmp_en) begin
        chk("m_pll_rst",   int'(pll_rst),   int'(m_ph == M_RESET || m_ph == M_FAULT));
        chk("m_audio_rst", int'(audio_rst), int'(m_ph != M_RUN));
        chk("m_pll_ready", int'(pll_ready), int'(m_ph == M_RUN));
        chk("m_fault",     int'(fault),     int'(m_ph == M_FAULT));
        chk("m_retry_cnt", int'(retry_cnt), m_retries);
        chk("m_lol_cnt",   int'(lol_cnt),   m_lol);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Retry sequence expectations: cycle, pll_rst, retry_cnt, fault.
  int t2_cyc[12] = '{3, 4, 23, 24, 27, 28, 47, 48, 51, 52, 71, 72};
  int t2_pr[12]  = '{1, 0,  0,  1,  1,  0,  0,  1,  1,  0,  0,  1};
  int t2_rc[12]  = '{0, 0,  0,  1,  1,  1,  1,  2,  2,  2,  2,  2};
  int t2_ft[12]  = '{0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1};

  initial begin
    int cur;
    cyc(3);
    chk("reset_pll_rst",   int'(pll_rst),   1);
    chk("reset_audio_rst", int'(audio_rst), 1);
    chk("reset_pll_ready", int'(pll_ready), 0);
    chk("reset_fault",     int'(fault),     0);
    chk("reset_retry_cnt", int'(retry_cnt), 0);
    chk("reset_lol_cnt",   int'(lol_cnt),   0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Nominal bring-up, lock at cycle 10 -> ready at cycle 21.
    cyc(3);  chk("nom_pll_rst_c3", int'(pll_rst), 1);
    cyc(1);  chk("nom_pll_rst_c4", int'(pll_rst), 0);
    cyc(6);  locked = 1'b1;
    cyc(10); chk("nom_ready_c20", int'(pll_ready), 0);
    chk("nom_audio_rst_c20", int'(audio_rst), 1);
    cyc(1);  chk("nom_ready_c21", int'(pll_ready), 1);
    chk("nom_audio_rst_c21", int'(audio_rst), 0);

    // Loss of lock in RUN.
    cyc(3);  locked = 1'b0;
    cyc(2);  chk("lol_ready_d2", int'(pll_ready), 1);
    cyc(1);  chk("lol_audio_rst_d3", int'(audio_rst), 1);
    chk("lol_ready_d3", int'(pll_ready), 0);
    chk("lol_cnt_d3",   int'(lol_cnt),   1);
    cyc(3);  chk("lol_pll_rst_d6", int'(pll_rst), 1);
    cyc(1);  chk("lol_pll_rst_d7", int'(pll_rst), 0);

    // Restart coinciding with a synced lock drop, lol_cnt=1.
    locked = 1'b1;
    wait_ready(40, "prio1_ready");
    locked = 1'b0;
    cyc(2);  restart = 1'b1;
    cyc(1);  restart = 1'b0;
    chk("prio1_pll_rst", int'(pll_rst), 1);
    chk("prio1_lol_cnt", int'(lol_cnt), 1);

    // Glitch: lock drops mid-STABLE.
    cyc(6);  locked = 1'b1;
    cyc(7);  locked = 1'b0;
    cyc(5);  chk("glitch_audio_rst", int'(audio_rst), 1);
    chk("glitch_pll_rst",   int'(pll_rst),   0);
    chk("glitch_retry_cnt", int'(retry_cnt), 0);

    // Lock drop coinciding with STABLE expiry -> no RUN.
    locked = 1'b1;
    cyc(8);  locked = 1'b0;
    cyc(3);  chk("coinc_ready_l11", int'(pll_ready), 0);
    cyc(1);  chk("coinc_ready_l12", int'(pll_ready), 0);
    chk("coinc_pll_rst_l12", int'(pll_rst), 0);

    // Async reset mid-STABLE without a clock edge.
    locked = 1'b1;
    cyc(5);
    #2 rst = 1'b1;
    #1;
    chk("async_pll_rst",   int'(pll_rst),   1);
    chk("async_audio_rst", int'(audio_rst), 1);
    chk("async_lol_cnt",   int'(lol_cnt),   0);
    locked = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Retry to fault with locked held low.
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(t2_cyc[i] - cur);
      cur = t2_cyc[i];
      chk($sformatf("retry_pll_rst_c%0d", cur), int'(pll_rst),   t2_pr[i]);
      chk($sformatf("retry_cnt_c%0d", cur),     int'(retry_cnt), t2_rc[i]);
      chk($sformatf("retry_fault_c%0d", cur),   int'(fault),     t2_ft[i]);
    end
    cyc(8);  chk("fault_held", int'(fault), 1);
    restart = 1'b1;
    cyc(1);  restart = 1'b0;
    chk("restart_fault",     int'(fault),     0);
    chk("restart_pll_rst",   int'(pll_rst),   1);
    chk("restart_retry_cnt", int'(retry_cnt), 0);
    cyc(3);  chk("restart_pll_rst_3", int'(pll_rst), 1);
    cyc(1);  chk("restart_pll_rst_4", int'(pll_rst), 0);

    // Saturation of lol_cnt over 300 drops.
    locked = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_ready(40, "sat_ready");
      locked = 1'b0;
      cyc(1);  locked = 1'b1;
      cyc(3);
    end
    wait_ready(40, "sat_ready_final");
    chk("sat_lol_cnt", int'(lol_cnt), 255);

    // Restart with a coincident lock drop at saturation.
    locked = 1'b0;
    cyc(2);  restart = 1'b1;
    cyc(1);  restart = 1'b0;
    chk("prio2_pll_rst",   int'(pll_rst),   1);
    chk("prio2_ready",     int'(pll_ready), 0);
    chk("prio2_lol_cnt",   int'(lol_cnt),   255);
    cyc(2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
